id_stage_skid_reg: RTL and testbench

Parametrised ID→EX pipeline register with a valid/ready handshake and a 2-entry skid buffer. It replaces the fixed-field stall/flush register between decode and execute. Decoded fields are carried as one opaque payload vector. A registered upstream ready breaks the combinational stall path, and flush and stall interact deterministically with in-flight entries.

---
 rtl/id_stage_skid_reg_if.sv | 32 +++
 rtl/id_stage_skid_reg.sv | 95 +++++++++
 tb/tb_id_stage_skid_reg.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/id_stage_skid_reg_if.sv
// Purpose: one valid/ready hop carrying a decoded ID->EX entry (pc, payload, exception).
// Latency: none, wires only.
// Backpressure: ready flows from the receiver (slave) back to the sender (master).
interface id_stage_skid_reg_if #(
    parameter int PC_W      = 30,
    parameter int PAYLOAD_W = 128,
    parameter int EXP_W     = 3
);
    logic                 valid;
    logic                 ready;
    logic [PC_W-1:0]      pc;
    logic [PAYLOAD_W-1:0] payload;
    logic [EXP_W-1:0]     exp;

    // Sender side: presents the entry, observes ready.
    modport master (
        output valid,
        output pc,
        output payload,
        output exp,
        input  ready
    );

    // Receiver side: observes the entry, returns ready.
    modport slave (
        input  valid,
        input  pc,
        input  payload,
        input  exp,
        output ready
    );
endinterface

// File: rtl/id_stage_skid_reg.sv
// Purpose: ID->EX pipeline register with a 2-entry (main + skid) buffer, flush and stall.
// Latency: 1 cycle from accepting edge to out_valid; 1 entry/cycle sustained.
// Backpressure: in_ready is ~skid.valid (register only), so one extra entry is absorbed when blocked.
module id_stage_skid_reg #(
    parameter int                   PAYLOAD_W   = 128,
    parameter int                   PC_W        = 30,
    parameter int                   EXP_W       = 3,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0
) (
    input  logic                     clk,
    input  logic                     reset_,
    id_stage_skid_reg_if.slave       up,
    id_stage_skid_reg_if.master      dn,
    input  logic                     stall,
    input  logic                     flush,
    output logic [1:0]               occupancy
);

    typedef struct packed {
        logic                 vld;
        logic [PC_W-1:0]      pc;
        logic [PAYLOAD_W-1:0] payload;
        logic [EXP_W-1:0]     exp;
    } entry_t;

    // An empty slot always looks like a bubble so execute can ignore out_valid safely.
    localparam entry_t NOP_ENT = '{
        vld:     1'b0,
        pc:      '0,
        payload: NOP_PAYLOAD,
        exp:     '0
    };

    entry_t m_q;      // main entry, drives the execute side
    entry_t s_q;      // skid entry, always younger than m_q
    entry_t in_ent;
    logic   in_rdy;
    logic   acc;
    logic   drn;

    // in_ready is a pure function of the skid register: no path from out_ready/stall.
    assign in_rdy = ~s_q.vld;

    // Capture the incoming entry as a valid slot.
    always_comb begin
        in_ent         = NOP_ENT;
        in_ent.vld     = 1'b1;
        in_ent.pc      = up.pc;
        in_ent.payload = up.payload;
        in_ent.exp     = up.exp;
    end

    // Handshake qualifiers: flush kills both sides, stall only blocks the drain.
    always_comb begin
        acc = up.valid & in_rdy & ~flush;
        drn = m_q.vld & dn.ready & ~stall & ~flush;
    end

    // Entry movement: reset > flush > fill/drain/skid shuffle, keeping arrival order.
    always_ff @(posedge clk) begin
        if (reset_) begin
            m_q <= NOP_ENT;
            s_q <= NOP_ENT;
        end else if (flush) begin
            m_q <= NOP_ENT;
            s_q <= NOP_ENT;
        end else if (!m_q.vld) begin
            // Skid is never occupied while main is empty, so input goes straight to main.
            if (acc) begin
                m_q <= in_ent;
            end
        end else if (drn) begin
            if (s_q.vld) begin
                // Older skid entry moves up; acc cannot happen since in_ready is low.
                m_q <= s_q;
                s_q <= NOP_ENT;
            end else if (acc) begin
                m_q <= in_ent;
            end else begin
                m_q <= NOP_ENT;
            end
        end else if (acc) begin
            // Main is blocked: absorb exactly one more entry into the skid slot.
            s_q <= in_ent;
        end
    end

    assign up.ready    = in_rdy;
    assign dn.valid    = m_q.vld;
    assign dn.pc       = m_q.pc;
    assign dn.payload  = m_q.payload;
    assign dn.exp      = m_q.exp;
    assign occupancy   = {1'b0, m_q.vld} + {1'b0, s_q.vld};

endmodule

// File: tb/tb_id_stage_skid_reg.sv
// Purpose: directed check of the ID->EX skid register: streaming, backpressure, stall, flush, reset.
// Latency: inputs driven #1 after each rising edge, outputs checked at that same point.
// Backpressure: exercised by holding out_ready low and by stall.
module tb_id_stage_skid_reg;

    localparam int PC_W      = 30;
    localparam int PAYLOAD_W = 128;
    localparam int EXP_W     = 3;
    localparam logic [PAYLOAD_W-1:0] NOP = 128'h0BAD_F00D;

    logic       clk;
    logic       reset_;
    logic       stall;
    logic       flush;
    logic [1:0] occupancy;

    int n_assert = 0;
    int n_fail   = 0;

    id_stage_skid_reg_if #(.PC_W(PC_W), .PAYLOAD_W(PAYLOAD_W), .EXP_W(EXP_W)) up_if ();
    id_stage_skid_reg_if #(.PC_W(PC_W), .PAYLOAD_W(PAYLOAD_W), .EXP_W(EXP_W)) dn_if ();

    id_stage_skid_reg #(
        .PAYLOAD_W   (PAYLOAD_W),
        .PC_W        (PC_W),
        .EXP_W       (EXP_W),
        .NOP_PAYLOAD (NOP)
    ) dut (
        .clk       (clk),
        .reset_    (reset_),
        .up        (up_if),
        .dn        (dn_if),
        .stall     (stall),
        .flush     (flush),
        .occupancy (occupancy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [EXP_W-1:0] ex);
        up_if.valid   = v;
        up_if.pc      = pc;
        up_if.payload = {{(PAYLOAD_W-PC_W){1'b0}}, pc};
        up_if.exp     = ex;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Check the whole execute-side view: valid, pc, payload (payload == pc for valid entries), exp.
    task automatic chk_out(input string tag, input logic v, input logic [PC_W-1:0] pc,
                           input logic [EXP_W-1:0] ex, input logic [1:0] occ, input logic rdy);
        logic [127:0] pl;
        pl = v ? {{(128-PC_W){1'b0}}, pc} : NOP;
        chk({tag, ".valid"},   {127'd0, dn_if.valid},   {127'd0, v});
        chk({tag, ".pc"},      {98'd0, dn_if.pc},       {98'd0, pc});
        chk({tag, ".payload"}, dn_if.payload,           pl);
        chk({tag, ".exp"},     {125'd0, dn_if.exp},     {125'd0, ex});
        chk({tag, ".occ"},     {126'd0, occupancy},     {126'd0, occ});
        chk({tag, ".in_ready"},{127'd0, up_if.ready},   {127'd0, rdy});
    endtask

    initial begin
        reset_ = 1'b1;
        stall  = 1'b0;
        flush  = 1'b0;
        dn_if.ready = 1'b1;
        drive(1'b0, '0, '0);

        // Reset state
        tick();
        tick();
        reset_ = 1'b0;
        chk_out("reset", 1'b0, '0, '0, 2'd0, 1'b1);

        // Stream 0x10..0x13 with out_ready=1: each shows up right after its accepting edge
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, PC_W'(32'h10 + i), '0);
            tick();
            chk_out($sformatf("stream%0d", i), 1'b1, PC_W'(32'h10 + i), '0, 2'd1, 1'b1);
        end
        drive(1'b0, '0, '0);
        tick();
        chk_out("stream_drain", 1'b0, '0, '0, 2'd0, 1'b1);

        // Backpressure: 0x20 in main, 0x21 in skid, 0x22 held upstream
        dn_if.ready = 1'b0;
        drive(1'b1, 30'h20, '0);
        tick();
        chk_out("bp_m", 1'b1, 30'h20, '0, 2'd1, 1'b1);
        drive(1'b1, 30'h21, '0);
        tick();
        chk_out("bp_s", 1'b1, 30'h20, '0, 2'd2, 1'b0);
        drive(1'b1, 30'h22, '0);
        tick();
        chk_out("bp_hold", 1'b1, 30'h20, '0, 2'd2, 1'b0);
        dn_if.ready = 1'b1;
        tick();
        chk_out("bp_rel1", 1'b1, 30'h21, '0, 2'd1, 1'b1);
        tick();
        chk_out("bp_rel2", 1'b1, 30'h22, '0, 2'd1, 1'b1);
        drive(1'b0, '0, '0);
        tick();
        chk_out("bp_empty", 1'b0, '0, '0, 2'd0, 1'b1);

        // Stall with out_ready=1: no drain, but fill continues into the skid
        drive(1'b1, 30'h30, '0);
        tick();
        chk_out("st_m", 1'b1, 30'h30, '0, 2'd1, 1'b1);
        stall = 1'b1;
        drive(1'b0, '0, '0);
        tick();
        chk_out("st_hold", 1'b1, 30'h30, '0, 2'd1, 1'b1);
        drive(1'b1, 30'h31, '0);
        tick();
        chk_out("st_fill", 1'b1, 30'h30, '0, 2'd2, 1'b0);
        drive(1'b0, '0, '0);
        tick();
        chk_out("st_hold2", 1'b1, 30'h30, '0, 2'd2, 1'b0);
        stall = 1'b0;
        tick();
        chk_out("st_rel", 1'b1, 30'h31, '0, 2'd1, 1'b1);
        tick();
        chk_out("st_empty", 1'b0, '0, '0, 2'd0, 1'b1);

        // Flush with both entries full, during stall, with a live input 0x40
        dn_if.ready = 1'b0;
        drive(1'b1, 30'h38, 3'd2);
        tick();
        drive(1'b1, 30'h39, 3'd1);
        tick();
        chk_out("fl_full", 1'b1, 30'h38, 3'd2, 2'd2, 1'b0);
        dn_if.ready = 1'b1;
        stall = 1'b1;
        flush = 1'b1;
        drive(1'b1, 30'h40, 3'd4);
        tick();
        chk_out("fl_clr", 1'b0, '0, '0, 2'd0, 1'b1);
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, '0, '0);
        tick();
        chk_out("fl_gone", 1'b0, '0, '0, 2'd0, 1'b1);

        // Exceptions stay paired with their own entry through the skid
        dn_if.ready = 1'b0;
        drive(1'b1, 30'h50, 3'd1);
        tick();
        chk_out("ex_m", 1'b1, 30'h50, 3'd1, 2'd1, 1'b1);
        drive(1'b1, 30'h51, 3'd3);
        tick();
        chk_out("ex_s", 1'b1, 30'h50, 3'd1, 2'd2, 1'b0);
        drive(1'b0, '0, '0);
        dn_if.ready = 1'b1;
        tick();
        chk_out("ex_rel", 1'b1, 30'h51, 3'd3, 2'd1, 1'b1);
        tick();
        chk_out("ex_bub", 1'b0, '0, '0, 2'd0, 1'b1);

        // Reset mid-stream with occupancy=2 and stall=1
        dn_if.ready = 1'b0;
        drive(1'b1, 30'h60, 3'd5);
        tick();
        drive(1'b1, 30'h61, 3'd6);
        tick();
        chk_out("rs_full", 1'b1, 30'h60, 3'd5, 2'd2, 1'b0);
        stall  = 1'b1;
        reset_ = 1'b1;
        drive(1'b1, 30'h62, 3'd7);
        tick();
        chk_out("rs_clr", 1'b0, '0, '0, 2'd0, 1'b1);
        reset_ = 1'b0;
        stall  = 1'b0;
        drive(1'b0, '0, '0);
        tick();
        chk_out("rs_idle", 1'b0, '0, '0, 2'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
